text_buf_ctrl: RTL and testbench
================================

TEXT_BUF_CTRL -- requirements
Module: text_buf_ctrl

Interface
REQ-001 Parameter N_CH, default 13: number of voltage channels and of text lines.
REQ-002 Parameter LINE_CHARS, default 12: characters per text line; line n starts at address n*LINE_CHARS.
REQ-003 pclk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 vblnk_in  input  1  vertical blanking; char RAM writes only while high.
REQ-006 req  input  N_CH  per-channel update request, level, held until ack.
REQ-007 ch_bcd  input  16*N_CH  per-channel 4-digit BCD millivolts; channel k at bits [16k+15:16k], MSD first.
REQ-008 ack  output  N_CH  one-cycle pulse to the channel whose line write completed.
REQ-009 wr_en  output  1  char RAM write strobe.
REQ-010 wr_addr  output  8  char RAM address.
REQ-011 wr_data  output  8  ASCII code written.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 FSM states: INIT, IDLE, LOAD, WRITE, ACK.
REQ-014 INIT: after reset, write all N_CH*LINE_CHARS cells with each line's default text, then enter IDLE.
REQ-015 Line layout for channel k: 'C','H', tens and units of k+1 as ASCII, ' ', d3, '.', d2, d1, d0, 'V', ' '.
REQ-016 INIT default digits: '0' for all four digits.
REQ-017 IDLE: when any req bit is high, select one channel by round-robin and go to LOAD next cycle.
REQ-018 Round-robin: search starts at the channel after the last granted one; after reset it starts at channel 0.
REQ-019 LOAD: capture the granted channel's ch_bcd into an internal register (one cycle); later ch_bcd changes do not affect the line being written.
REQ-020 WRITE: one character per cycle, addresses base..base+LINE_CHARS-1 in ascending order, with wr_en high.
REQ-021 wr_en, wr_addr and wr_data are registered; they change on the same edge.
REQ-022 When vblnk_in is low in INIT or WRITE: hold wr_en low, freeze the character counter, and resume at the same address once vblnk_in is high again.
REQ-023 BCD digit greater than 9: write '?' (8'h3F).
REQ-024 After the last character: go to ACK, pulse ack for the granted channel for 1 cycle, then return to IDLE.
REQ-025 A req deasserted before grant is ignored; a req still high after ack is a new request.
REQ-026 Minimum latency from IDLE with req seen and vblnk_in high to ack: 1 (arbitrate) + 1 (LOAD) + LINE_CHARS (WRITE) + 1 (ACK) cycles.
REQ-027 wr_addr arithmetic: 8 bits unsigned; N_CH*LINE_CHARS must not exceed 256, checked at elaboration.

Reset
REQ-028 On rst low, immediately: wr_en=0, wr_addr=0, wr_data=0, ack=0, busy=1, state=INIT, character counter=0, round-robin pointer=channel 0.
REQ-029 Reset asserted mid-WRITE abandons the line with no ack; INIT then rewrites every line with defaults.

Structure
REQ-030 The shared package text_buf_pkg holds: N_CH and LINE_CHARS defaults, the ASCII constants ('C','H','.','V',' ','?','0'), and the state encoding.
REQ-031 Round-robin selection lives in one sub-module, rr_arbiter (inputs req and last grant; output one-hot grant); everything else is in text_buf_ctrl.

Verification
REQ-032 Reset release with vblnk_in=1: 156 consecutive writes; addr 0..11 = "CH01 0.000V ", addr 144..155 = "CH13 0.000V "; busy falls afterwards.
REQ-033 req[2]=1, ch_bcd[47:32]=16'h3456, vblnk_in=1: addrs 24..35 receive "CH03 3.456V "; ack[2] pulses exactly 15 cycles after req is sampled.
REQ-034 req[0], req[5], req[12] raised together and held until each ack: acks arrive in order 0, 5, 12; a second round also gives 0, 5, 12.
REQ-035 vblnk_in drops after the 4th character of a line and returns 100 cycles later: no wr_en during the gap; the write resumes at base+4; no address is repeated or skipped.
REQ-036 ch_bcd = 16'h9A01: '?' written at base+7; ch_bcd changed to 16'h1111 after LOAD: line still shows 9.?01.
REQ-037 rst pulsed low mid-WRITE of channel 7: outputs reach reset values within the same cycle; no ack[7]; full INIT sequence repeats.

Source files
------------

// File: rtl/text_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_buf_pkg
// Description : Shared definitions for the voltage text-buffer controller.
//               Holds the default geometry, the ASCII codes used to build a
//               line, the controller state encoding, and the BCD-to-ASCII
//               digit helper.
// Revision    : 1.0  initial release
// ============================================================================
package text_buf_pkg;

    localparam int c_N_CH_DEF       = 13;
    localparam int c_LINE_CHARS_DEF = 12;
    localparam int c_ADDR_SPACE     = 256;

    localparam logic [7:0] c_ascii_c   = 8'h43;  // 'C'
    localparam logic [7:0] c_ascii_h   = 8'h48;  // 'H'
    localparam logic [7:0] c_ascii_dot = 8'h2E;  // '.'
    localparam logic [7:0] c_ascii_v   = 8'h56;  // 'V'
    localparam logic [7:0] c_ascii_sp  = 8'h20;  // ' '
    localparam logic [7:0] c_ascii_q   = 8'h3F;  // '?'
    localparam logic [7:0] c_ascii_0   = 8'h30;  // '0'

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    // A nibble that is not a valid decimal digit is shown as '?'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? c_ascii_q : (c_ascii_0 + {4'b0000, d});
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search begins at the
//               channel after the last granted one; an all-zero last grant
//               means "nothing granted yet" and the search begins at 0.
// Ports       : req_i      - request vector
//               last_gnt_i - one-hot last grant (or all zero)
//               gnt_o      - one-hot grant (all zero when no request)
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 13
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_gnt_i,
    output logic [N-1:0] gnt_o
);

    int   w_start;
    int   w_idx;
    logic w_found;

    always_comb begin
        w_start = 0;
        for (int i = 0; i < N; i++) begin
            if (last_gnt_i[i]) begin
                w_start = (i + 1) % N;
            end
        end
        gnt_o   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (w_start + i) % N;
            if (!w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/text_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_buf_ctrl
// Description : Writes one text line per voltage channel into a character
//               RAM. After reset every line gets its default text; then
//               channels requesting an update are served round-robin, their
//               BCD reading captured once and the line rewritten one
//               character per cycle, only during vertical blanking.
// Ports       : pclk     - clock (rising edge)
//               rst      - asynchronous active-low reset
//               vblnk_in - vertical blanking, RAM writes allowed while high
//               req      - per-channel update request (level)
//               ch_bcd   - per-channel 4-digit BCD millivolts, MSD first
//               ack      - one-cycle pulse to the channel just written
//               wr_en    - char RAM write strobe
//               wr_addr  - char RAM address
//               wr_data  - ASCII code
//               busy     - controller not idle
// Revision    : 1.0  initial release
// ============================================================================
module text_buf_ctrl
    import text_buf_pkg::*;
#(
    parameter int N_CH       = c_N_CH_DEF,
    parameter int LINE_CHARS = c_LINE_CHARS_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 vblnk_in,
    input  logic [N_CH-1:0]      req,
    input  logic [16*N_CH-1:0]   ch_bcd,
    output logic [N_CH-1:0]      ack,
    output logic                 wr_en,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);

    localparam int LINE_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W  = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;

    localparam logic [LINE_W-1:0] c_last_line = LINE_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]  c_last_char = CNT_W'(LINE_CHARS - 1);

    generate
        if (N_CH * LINE_CHARS > c_ADDR_SPACE) begin : g_size_check
            $error("text_buf_ctrl: N_CH*LINE_CHARS exceeds 8-bit address space");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [N_CH-1:0]     gnt_q, gnt_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                wr_en_q, wr_en_d;
    logic [7:0]          wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [N_CH-1:0]     ack_q, ack_d;

    logic [N_CH-1:0]     w_req;
    logic [N_CH-1:0]     w_gnt;
    logic [LINE_W-1:0]   w_gnt_idx;
    logic [7:0]          w_addr;

    // Character at position pos of line 'line' for a given BCD reading.
    function automatic logic [7:0] char_at(input logic [CNT_W-1:0] pos,
                                           input logic [LINE_W-1:0] line,
                                           input logic [15:0] bcd);
        int         num;
        logic [7:0] ch;
        num = int'(line) + 1;
        case (int'(pos))
            0:       ch = c_ascii_c;
            1:       ch = c_ascii_h;
            2:       ch = c_ascii_0 + 8'(num / 10);
            3:       ch = c_ascii_0 + 8'(num % 10);
            4:       ch = c_ascii_sp;
            5:       ch = bcd_to_ascii(bcd[15:12]);
            6:       ch = c_ascii_dot;
            7:       ch = bcd_to_ascii(bcd[11:8]);
            8:       ch = bcd_to_ascii(bcd[7:4]);
            9:       ch = bcd_to_ascii(bcd[3:0]);
            10:      ch = c_ascii_v;
            default: ch = c_ascii_sp;
        endcase
        return ch;
    endfunction

    // The channel acked this cycle is masked so its still-high request is
    // not mistaken for a new one before the requester has seen the ack.
    assign w_req = req & ~ack_q;

    rr_arbiter #(
        .N (N_CH)
    ) u_rr_arbiter (
        .req_i      (w_req),
        .last_gnt_i (gnt_q),
        .gnt_o      (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = LINE_W'(i);
            end
        end
    end

    assign w_addr = 8'(int'(line_q) * LINE_CHARS + int'(cnt_q));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            line_q    <= '0;
            gnt_q     <= '0;
            bcd_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            gnt_q     <= gnt_d;
            bcd_q     <= bcd_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        gnt_d     = gnt_q;
        bcd_d     = bcd_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ack_d     = '0;
        case (state_q)
            ST_INIT: begin
                if (vblnk_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_addr;
                    wr_data_d = char_at(cnt_q, line_q, 16'h0000);
                    if (cnt_q == c_last_char) begin
                        cnt_d = '0;
                        if (line_q == c_last_line) begin
                            line_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (|w_req) begin
                    gnt_d   = w_gnt;
                    line_d  = w_gnt_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bcd_d   = ch_bcd[int'(line_q) * 16 +: 16];
                cnt_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (vblnk_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_addr;
                    wr_data_d = char_at(cnt_q, line_q, bcd_q);
                    if (cnt_q == c_last_char) begin
                        cnt_d   = '0;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                ack_d   = gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign ack     = ack_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_text_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_buf_ctrl
// Description : Directed self-checking bench for text_buf_ctrl. A negedge
//               monitor mirrors the character RAM and logs every write
//               address; the directed steps compare against hand-derived
//               line text, addresses and latencies.
// Revision    : 1.0  initial release
// ============================================================================
module tb_text_buf_ctrl;

    localparam int N_CH = 13;
    localparam int LC   = 12;

    logic                pclk     = 1'b0;
    logic                rst      = 1'b1;
    logic                vblnk_in = 1'b1;
    logic [N_CH-1:0]     req      = '0;
    logic [16*N_CH-1:0]  ch_bcd   = '0;
    wire  [N_CH-1:0]     ack;
    wire                 wr_en;
    wire  [7:0]          wr_addr;
    wire  [7:0]          wr_data;
    wire                 busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    int         wlog[$];
    int         ack7_cnt = 0;

    text_buf_ctrl #(
        .N_CH       (N_CH),
        .LINE_CHARS (LC)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .req      (req),
        .ch_bcd   (ch_bcd),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            wlog.push_back(int'(wr_addr));
        end
        if (ack[7]) ack7_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic string dch(input logic [3:0] d);
        return (d > 4'd9) ? "?" : $sformatf("%0d", d);
    endfunction

    function automatic string exp_line(input int ch, input logic [15:0] bcd);
        string s;
        s = $sformatf("CH%02d ", ch + 1);
        s = {s, dch(bcd[15:12]), ".", dch(bcd[11:8]), dch(bcd[7:4]), dch(bcd[3:0]), "V "};
        return s;
    endfunction

    task automatic chk_line(input int ch, input logic [15:0] bcd);
        string s;
        s = exp_line(ch, bcd);
        for (int i = 0; i < LC; i++) begin
            chk($sformatf("line%0d_char%0d", ch, i), {24'h0, mem[ch*LC+i]}, {24'h0, s[i]});
        end
    endtask

    // Writes logged since index 'start' must be base, base+1, ... exactly n long.
    task automatic chk_seq(input string tag, input int start, input int base, input int n);
        int errs;
        errs = 0;
        chk({tag, "_count"}, wlog.size() - start, n);
        for (int i = 0; i < n; i++) begin
            if (start + i >= wlog.size() || wlog[start+i] != base + i) errs++;
        end
        chk({tag, "_order"}, errs, 0);
    endtask

    task automatic wait_ack(input int ch, input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (ack[ch]) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (!busy) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int start;
        int n;
        int viol;
        int got;
        int order[3];
        logic [N_CH-1:0] a;

        // ---- reset state ----
        #1 rst = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 1);

        // ---- INIT after reset release ----
        @(negedge pclk);
        start = wlog.size();
        rst   = 1'b1;
        wait_idle(400, k);
        chk("init_cycles", k, 156);
        tick();
        chk("init_busy", busy, 0);
        chk_seq("init", start, 0, 156);
        chk_line(0, 16'h0000);
        chk_line(12, 16'h0000);

        // ---- round-robin order, two rounds ----
        for (int r = 0; r < 2; r++) begin
            @(negedge pclk);
            req = 13'h1021;
            got = 0;
            for (int c = 0; c < 200 && got < 3; c++) begin
                tick();
                if (ack != 0) begin
                    a = ack;
                    for (int i = 0; i < N_CH; i++) if (a[i]) order[got] = i;
                    got++;
                    @(negedge pclk);
                    req = req & ~a;
                end
            end
            chk($sformatf("rr%0d_count", r), got, 3);
            chk($sformatf("rr%0d_first", r), order[0], 0);
            chk($sformatf("rr%0d_second", r), order[1], 5);
            chk($sformatf("rr%0d_third", r), order[2], 12);
        end
        req = '0;

        // ---- single channel update, latency ----
        @(negedge pclk);
        ch_bcd[47:32] = 16'h3456;
        req[2]        = 1'b1;
        start         = wlog.size();
        wait_ack(2, 40, k);
        chk("ch2_latency", k, 15);
        chk("ch2_ack_onehot", ack, 13'h0004);
        @(negedge pclk);
        req[2] = 1'b0;
        tick();
        chk("ch2_ack_width", ack, 0);
        chk_seq("ch2", start, 24, 12);
        chk_line(2, 16'h3456);

        // ---- blanking gap after the 4th character ----
        @(negedge pclk);
        ch_bcd[31:16] = 16'h1234;
        req[1]        = 1'b1;
        start         = wlog.size();
        n             = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (wr_en) n++;
        end
        chk("gap_pre_writes", n, 4);
        vblnk_in = 1'b0;
        viol     = 0;
        repeat (100) begin
            tick();
            if (wr_en) viol++;
        end
        chk("gap_no_wr_en", viol, 0);
        vblnk_in = 1'b1;
        wait_ack(1, 40, k);
        chk("gap_ack_seen", (k > 0), 1);
        @(negedge pclk);
        req[1] = 1'b0;
        tick();
        chk_seq("gap", start, 12, 12);
        chk("gap_resume_addr", (wlog.size() > start + 4) ? wlog[start+4] : -1, 16);
        chk_line(1, 16'h1234);

        // ---- invalid digit, input change after LOAD ----
        @(negedge pclk);
        ch_bcd[159:144] = 16'h9A01;
        req[9]          = 1'b1;
        repeat (3) tick();
        ch_bcd[159:144] = 16'h1111;
        wait_ack(9, 40, k);
        chk("ch9_latency_rest", k, 12);
        @(negedge pclk);
        req[9] = 1'b0;
        tick();
        chk("ch9_qmark", mem[9*LC+7], 8'h3F);
        chk_line(9, 16'h9A01);

        // ---- reset mid-write ----
        @(negedge pclk);
        ch_bcd[127:112] = 16'h7777;
        req[7]          = 1'b1;
        n               = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (wr_en) n++;
        end
        chk("ch7_pre_writes", n, 5);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_busy", busy, 1);
        req = '0;
        k   = ack7_cnt;
        repeat (2) @(negedge pclk);
        start = wlog.size();
        rst   = 1'b1;
        wait_idle(400, n);
        chk("reinit_cycles", n, 156);
        tick();
        chk_seq("reinit", start, 0, 156);
        chk_line(7, 16'h0000);
        chk_line(9, 16'h0000);
        chk("no_ack7", ack7_cnt - k, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
